apu_issue_queue: RTL

Request buffer between the host core's APU master port and the `accelerator_top` APU slave port. It accepts offloaded vector instructions into an in-order FIFO and issues them one at a time to the accelerator with a valid/grant handshake. It caps the number of issued-but-uncompleted instructions and registers returned results back to the core. The core can therefore keep offloading while the decoder or arithmetic stage is stalled.

---
 rtl/accelerator_pkg.sv | 12 +
 rtl/apu_req_fifo.sv | 69 ++++++
 rtl/apu_issue_queue.sv | 134 +++++++++++++
 3 files changed

// File: rtl/accelerator_pkg.sv
// rtl/accelerator_pkg.sv - shared APU request type and result-flag width for the accelerator slice.
package accelerator_pkg;

   localparam int APU_RESULT_FLAGS_W = 5;

   typedef struct packed {
      logic [2:0][31:0] operands;
      logic [5:0]       op;
      logic [14:0]      flags;
   } apu_req_t;

endpackage

// File: rtl/apu_req_fifo.sv
// rtl/apu_req_fifo.sv - in-order request FIFO holding apu_req_t entries.
// full/empty are decoded from the registered occupancy count only.
module apu_req_fifo
   import accelerator_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  apu_req_t                     push_data,
   input  logic                         pop,
   output apu_req_t                     pop_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   apu_req_t            mem_q [DEPTH];
   apu_req_t            mem_d [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;

endmodule

// File: rtl/apu_issue_queue.sv
// rtl/apu_issue_queue.sv - APU request buffer between core and accelerator_top with outstanding cap.
// Optional same-cycle bypass of an empty queue: define APU_QUEUE_BYPASS_EN.
module apu_issue_queue
   import accelerator_pkg::*;
#(
   parameter int DEPTH           = 4,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          core_req,
   input  logic [31:0]                   core_operands [2:0],
   input  logic [5:0]                    core_op,
   input  logic [14:0]                   core_flags_i,
   output logic                          core_gnt,
   output logic                          core_rvalid,
   output logic [31:0]                   core_result,
   output logic [APU_RESULT_FLAGS_W-1:0] core_flags_o,
   output logic                          acc_req,
   output logic [31:0]                   acc_operands [2:0],
   output logic [5:0]                    acc_op,
   output logic [14:0]                   acc_flags_i,
   input  logic                          acc_gnt,
   input  logic                          acc_rvalid,
   input  logic [31:0]                   acc_result,
   input  logic [APU_RESULT_FLAGS_W-1:0] acc_flags_o,
   output logic                          busy,
   output logic                          err_spurious
);

   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [OUT_W-1:0] MAX_OUT_V = OUT_W'(MAX_OUTSTANDING);

   apu_req_t                        core_payload;
   apu_req_t                        head_payload;
   apu_req_t                        issue_payload;
   logic                            fifo_full, fifo_empty;
   logic [$clog2(DEPTH+1)-1:0]      fifo_count;
   logic                            fifo_push, fifo_pop;
   logic                            can_issue, bypass, issued;
   logic                            result_ok, spurious;

   logic [OUT_W-1:0]                outstanding_q, outstanding_d;
   logic                            core_rvalid_q, core_rvalid_d;
   logic [31:0]                     core_result_q, core_result_d;
   logic [APU_RESULT_FLAGS_W-1:0]   core_flags_q, core_flags_d;
   logic                            err_spurious_q, err_spurious_d;

   always_comb begin
      core_payload = '0;
      for (int i = 0; i < 3; i++) begin
         core_payload.operands[i] = core_operands[i];
      end
      core_payload.op    = core_op;
      core_payload.flags = core_flags_i;
   end

   apu_req_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (core_payload),
      .pop       (fifo_pop),
      .pop_data  (head_payload),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign can_issue = (outstanding_q < MAX_OUT_V);
   assign core_gnt  = core_req && !fifo_full;

`ifdef APU_QUEUE_BYPASS_EN
   assign bypass = fifo_empty && core_req && can_issue;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed instruction taken by the accelerator never touches the FIFO.
   assign acc_req       = bypass || (!fifo_empty && can_issue);
   assign issue_payload = bypass ? core_payload : head_payload;
   assign issued        = acc_req && acc_gnt;
   assign fifo_pop      = issued && !bypass;
   assign fifo_push     = core_gnt && !(bypass && acc_gnt);

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         acc_operands[i] = issue_payload.operands[i];
      end
   end
   assign acc_op      = issue_payload.op;
   assign acc_flags_i = issue_payload.flags;

   assign result_ok = acc_rvalid && (outstanding_q != '0);
   assign spurious  = acc_rvalid && (outstanding_q == '0);

   always_comb begin
      outstanding_d = outstanding_q;
      case ({issued, result_ok})
         2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
         2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
         default: outstanding_d = outstanding_q;
      endcase
      core_rvalid_d  = result_ok;
      core_result_d  = result_ok ? acc_result  : core_result_q;
      core_flags_d   = result_ok ? acc_flags_o : core_flags_q;
      err_spurious_d = err_spurious_q || spurious;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         outstanding_q  <= '0;
         core_rvalid_q  <= 1'b0;
         core_result_q  <= '0;
         core_flags_q   <= '0;
         err_spurious_q <= 1'b0;
      end else begin
         outstanding_q  <= outstanding_d;
         core_rvalid_q  <= core_rvalid_d;
         core_result_q  <= core_result_d;
         core_flags_q   <= core_flags_d;
         err_spurious_q <= err_spurious_d;
      end
   end

   assign core_rvalid  = core_rvalid_q;
   assign core_result  = core_result_q;
   assign core_flags_o = core_flags_q;
   assign err_spurious = err_spurious_q;
   assign busy         = (fifo_count != '0) || (outstanding_q != '0);

endmodule
